// File: rtl/ob_pkg.sv
// Shared types and constants for the ob command multiplexer: command/response
// payloads, arbitration mode encodings and port-count limits.
package ob_pkg;

    localparam int N_PORTS_MIN  = 2;
    localparam int N_PORTS_MAX  = 8;
    localparam int N_PORTS_DFLT = 4;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // Port-select width for a given port count (at least one bit).
    function automatic int port_w(input int n_ports);
        return (n_ports <= 2) ? 1 : $clog2(n_ports);
    endfunction

    localparam int PORT_W = port_w(N_PORTS_DFLT);

    typedef struct packed {
        logic [7:0]  uid;
        logic [3:0]  op;
        logic [15:0] data;
    } cmd_t;

    typedef struct packed {
        logic [7:0]  uid;
        logic [15:0] data;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/ob_cmd_fifo.sv
// Per-port command FIFO: drops writes while full (sticky overflow flag) and
// registers the full flag from next-state occupancy.
module ob_cmd_fifo
    import ob_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic empty,
    output logic full_r,
    output logic ovf_r
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          wr_en;
    logic          rd_en;

    assign empty   = (cnt == '0);
    assign wr_en   = push & ~full_r;
    assign rd_en   = pop & ~empty;
    assign cnt_nxt = cnt + CW'(wr_en) - CW'(rd_en);
    assign head    = mem[rd_ptr];

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            cnt    <= cnt_nxt;
            full_r <= (cnt_nxt == CW'(DEPTH));
            ovf_r  <= ovf_r | (push & full_r);
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides which
    // entries are meaningful, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ob_cmd_mux.sv
// Multiplexes N_PORTS command FIFOs onto one registered ob command channel and
// routes ob responses back to the port encoded in the response uid.
module ob_cmd_mux
    import ob_pkg::*;
#(
    parameter int N_PORTS    = N_PORTS_DFLT,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = ARB_MODE_RR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] cmd_vld_r,
    input  cmd_t [N_PORTS-1:0] cmd_r,
    output logic [N_PORTS-1:0] cmd_full_r,
    output logic [N_PORTS-1:0] cmd_ovf_r,
    output logic               ob_cmd_vld_r,
    output cmd_t               ob_cmd_r,
    input  logic               ob_cmd_full_r,
    input  logic               ob_rsp_vld,
    input  rsp_t               ob_rsp,
    output logic               ob_rsp_accept,
    output logic [N_PORTS-1:0] rsp_vld,
    output rsp_t               rsp,
    input  logic [N_PORTS-1:0] rsp_accept
);

    localparam int PW = port_w(N_PORTS);

    logic [N_PORTS-1:0] empty;
    logic [N_PORTS-1:0] pop;
    cmd_t [N_PORTS-1:0] head;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      grant_idx;
    logic               grant_vld;
    cmd_t               grant_cmd;
    logic [PW-1:0]      rsp_sel;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        ob_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (cmd_vld_r[i]),
            .push_data (cmd_r[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .empty     (empty[i]),
            .full_r    (cmd_full_r[i]),
            .ovf_r     (cmd_ovf_r[i])
        );
    end

    // The output register is a one-cycle pulse, so it is always drained and
    // arbitration is gated by ob back-pressure alone.
    always_comb begin : p_arb
        int j;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!ob_cmd_full_r) begin
            if (ARB_MODE == ARB_MODE_FIXED) begin
                for (int i = N_PORTS - 1; i >= 0; i--) begin
                    if (!empty[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = PW'(i);
                    end
                end
            end else begin
                // Scan farthest-first so the nearest port after rr_ptr wins.
                for (int k = N_PORTS; k >= 1; k--) begin
                    j = int'(rr_ptr) + k;
                    if (j >= N_PORTS) j = j - N_PORTS;
                    for (int i = 0; i < N_PORTS; i++) begin
                        if (i == j && !empty[i]) begin
                            grant_vld = 1'b1;
                            grant_idx = PW'(i);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        pop       = '0;
        grant_cmd = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_idx == PW'(i)) begin
                pop[i]    = grant_vld;
                grant_cmd = head[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ob_cmd_vld_r <= 1'b0;
            ob_cmd_r     <= '0;
            rr_ptr       <= PW'(N_PORTS - 1);
        end else begin
            ob_cmd_vld_r <= grant_vld;
            if (grant_vld) begin
                ob_cmd_r <= grant_cmd;
                rr_ptr   <= grant_idx;
            end
        end
    end

    // Responses for a uid port index beyond N_PORTS are silently consumed.
    assign rsp     = ob_rsp;
    assign rsp_sel = ob_rsp.uid[PW-1:0];

    always_comb begin
        rsp_vld       = '0;
        ob_rsp_accept = ob_rsp_vld;
        for (int i = 0; i < N_PORTS; i++) begin
            if (rsp_sel == PW'(i)) begin
                rsp_vld[i]    = ob_rsp_vld;
                ob_rsp_accept = ob_rsp_vld & rsp_accept[i];
            end
        end
    end

endmodule

// File: doc/ob_cmd_mux.md
OB_CMD_MUX -- requirements
Module: ob_cmd_mux

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of command/response channels, range 2..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: per-port command FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port cmd_vld_r, input, N_PORTS: per-port command valid.
REQ-007 SHALL have port cmd_r, input, N_PORTS x ob_pkg::cmd_t: per-port command.
REQ-008 SHALL have port cmd_full_r, output, N_PORTS: per-port FIFO full, registered.
REQ-009 SHALL have port cmd_ovf_r, output, N_PORTS: sticky overflow flag, registered.
REQ-010 SHALL have port ob_cmd_vld_r, output, 1: command valid to ob, registered.
REQ-011 SHALL have port ob_cmd_r, output, ob_pkg::cmd_t: command to ob, registered.
REQ-012 SHALL have port ob_cmd_full_r, input, 1: ob cannot accept a command this cycle.
REQ-013 SHALL have port ob_rsp_vld, input, 1: response valid from ob.
REQ-014 SHALL have port ob_rsp, input, ob_pkg::rsp_t: response from ob.
REQ-015 SHALL have port ob_rsp_accept, output, 1: response consumed, combinational.
REQ-016 SHALL have port rsp_vld, output, N_PORTS: per-port response valid, combinational.
REQ-017 SHALL have port rsp, output, ob_pkg::rsp_t: response broadcast to all ports.
REQ-018 SHALL have port rsp_accept, input, N_PORTS: per-port response accept.

Function
REQ-019 SHALL write cmd_r[i] into FIFO i on any cycle with cmd_vld_r[i]=1 and FIFO i not full.
REQ-020 SHALL drive cmd_full_r[i] from next-state occupancy, so it is 1 in the cycle after occupancy reaches FIFO_DEPTH.
REQ-021 SHALL drop a write arriving while FIFO i is full and set cmd_ovf_r[i]=1 until rst.
REQ-022 SHALL use as candidates each port whose FIFO is non-empty, and SHALL arbitrate only when ob_cmd_full_r=0 and the output register is empty or is being drained.
REQ-023 SHALL, with ARB_MODE=0, grant the first candidate after the last-granted port in ascending wrap-around order; the pointer updates only on grant.
REQ-024 SHALL, with ARB_MODE=1, grant the lowest-index candidate.
REQ-025 SHALL pop the granted FIFO and load ob_cmd_r/ob_cmd_vld_r=1 in the same cycle; minimum latency from write to visible ob_cmd_vld_r is 2 cycles.
REQ-026 SHALL hold ob_cmd_vld_r high for exactly one cycle per command; ob_cmd_vld_r=0 whenever ob_cmd_full_r was 1 at the previous edge.
REQ-027 SHALL accept simultaneous write and pop on one FIFO; occupancy is then unchanged and full is unaffected.
REQ-028 SHALL route a response to port p = ob_rsp.uid[PORT_W-1:0], with PORT_W = clog2(N_PORTS): rsp_vld[p] = ob_rsp_vld, all other bits 0.
REQ-029 SHALL drive ob_rsp_accept = rsp_accept[p] & ob_rsp_vld, and SHALL ignore rsp_accept on non-selected ports.
REQ-030 SHALL treat p >= N_PORTS as a discard: auto-accept with no rsp_vld asserted.
REQ-031 SHALL pass ob_cmd_r through unmodified; uid encoding of the port is the producer's responsibility.

Reset
REQ-032 SHALL, on rst, clear all FIFOs, drive cmd_full_r=0, cmd_ovf_r=0 and ob_cmd_vld_r=0, set ob_cmd_r='0, and set the RR pointer to N_PORTS-1 so port 0 wins first.
REQ-033 SHALL, on rst mid-operation, discard queued and in-flight commands with no output the next cycle; the response path stays combinational.

Structure
REQ-034 SHALL place PORT_W, the ARB_MODE encodings and the N_PORTS limit in ob_pkg.
REQ-035 SHALL instantiate one sub-module, ob_cmd_fifo (parametrised depth and ob_pkg::cmd_t payload), per port.

Verification
REQ-036 SHALL test a single write on port 2 at cycle 10 with the ob not full: ob_cmd_vld_r=1 at cycle 12 with an identical cmd.
REQ-037 SHALL test all 4 ports writing one command in the same cycle, ARB_MODE=0: issue order 0,1,2,3 on consecutive cycles.
REQ-038 SHALL test 5 back-to-back writes to port 1 with ob_cmd_full_r=1 and FIFO_DEPTH=4: cmd_full_r[1]=1 after the 4th, the 5th is dropped, cmd_ovf_r[1]=1, then 4 commands issue after full deasserts.
REQ-039 SHALL test ARB_MODE=1 with ports 0 and 3 continuously loaded: port 3 is never granted while port 0 is non-empty.
REQ-040 SHALL test a response with uid=0x13, N_PORTS=4, and rsp_accept=4'b1000: rsp_vld=4'b1000 and ob_rsp_accept=1; with rsp_accept=4'b0001 instead, ob_rsp_accept=0.
REQ-041 SHALL test rst asserted with 3 queued commands: no ob_cmd_vld_r afterwards, and cmd_full_r=0 and cmd_ovf_r=0.
